// File: rtl/fetch_sequencer.sv
// ============================================================================
// fetch_sequencer : IF-stage PC owner, next-PC select, ROM addressing, halt
// Revision 1.0
// ============================================================================
`default_nettype none

module fetch_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          DELAY_SLOT = 1,
  parameter int          CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic             halt,
  input  logic [1:0]       pcsource,
  input  logic [31:0]      bpc,
  input  logic [31:0]      da,
  input  logic [31:0]      jpc,
  input  logic [31:0]      rom_ins,
  output logic [31:0]      rom_addr,
  output logic [31:0]      pc,
  output logic [31:0]      pc4,
  output logic [31:0]      ins,
  output logic             ins_valid,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] redir_cnt
);

  typedef enum logic [1:0] {
    S_BOOT   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  localparam logic SQUASH = (DELAY_SLOT == 0);

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] redir_cnt_q, redir_cnt_d;
  logic [31:0]      npc;
  logic             redirect;

  assign pc4      = pc_q + 32'd4;
  assign redirect = (pcsource != 2'b00);

  always_comb begin
    unique case (pcsource)
      2'b00:   npc = pc4;
      2'b01:   npc = bpc;
      2'b10:   npc = da;
      default: npc = jpc;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_BOOT;
      pc_q        <= RESET_PC;
      stall_cnt_q <= '0;
      redir_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      stall_cnt_q <= stall_cnt_d;
      redir_cnt_q <= redir_cnt_d;
    end
  end

  // The ROM always holds mem[pc] while in RUN: every cycle presents the
  // address that becomes pc on the same edge, so IF never needs a bubble.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    stall_cnt_d = stall_cnt_q;
    redir_cnt_d = redir_cnt_q;
    rom_addr    = pc_q;
    ins         = 32'h0;
    ins_valid   = 1'b0;
    halted      = 1'b0;
    unique case (state_q)
      S_BOOT: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        ins       = rom_ins;
        ins_valid = 1'b1;
        if (stall) begin
          if (stall_cnt_q != {CNT_W{1'b1}}) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end else begin
          rom_addr = npc;
          pc_d     = npc;
          if (redirect) begin
            if (redir_cnt_q != {CNT_W{1'b1}}) begin
              redir_cnt_d = redir_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            // Wrong-path instruction is dropped when there is no delay slot.
            if (SQUASH) begin
              ins       = 32'h0;
              ins_valid = 1'b0;
            end
          end
          if (halt) begin
            state_d = S_HALTED;
          end
        end
      end
      S_HALTED: begin
        halted = 1'b1;
      end
      default: begin
        state_d = S_BOOT;
      end
    endcase
  end

  assign pc        = pc_q;
  assign stall_cnt = stall_cnt_q;
  assign redir_cnt = redir_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
// ============================================================================
// tb_fetch_sequencer : directed + randomized check of two fetch_sequencer
// configurations against a behavioural model. Revision 1.0
// ============================================================================
`default_nettype none

module tb_fetch_sequencer;

  localparam int MB = 0;  // model state: boot
  localparam int MR = 1;  // model state: run
  localparam int MH = 2;  // model state: halted

  localparam logic [31:0] RST_A = 32'h0000_0000;
  localparam logic [31:0] RST_B = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        reset, stall, halt;
  logic [1:0]  pcsource;
  logic [31:0] bpc, da, jpc;

  logic [31:0] rom_ins_a, rom_addr_a, pc_a, pc4_a, ins_a;
  logic        ins_valid_a, halted_a;
  logic [15:0] stall_cnt_a, redir_cnt_a;

  logic [31:0] rom_ins_b, rom_addr_b, pc_b, pc4_b, ins_b;
  logic        ins_valid_b, halted_b;
  logic [2:0]  stall_cnt_b, redir_cnt_b;

  int n_tests = 0;
  int n_fail  = 0;

  int          m_state [2];
  logic [31:0] m_pc    [2];
  logic [31:0] m_sc    [2];
  logic [31:0] m_rc    [2];
  logic [31:0] m_rst   [2];
  logic [31:0] m_cmax  [2];
  int          m_ds    [2];

  logic [31:0] o_pc [2], o_pc4 [2], o_rom [2], o_ins [2], o_sc [2], o_rc [2];
  logic        o_v  [2], o_h [2];

  always #5 clk = ~clk;

  fetch_sequencer #(.RESET_PC(RST_A), .DELAY_SLOT(1), .CNT_W(16)) u_a (
    .clock(clk), .reset(reset), .stall(stall), .halt(halt), .pcsource(pcsource),
    .bpc(bpc), .da(da), .jpc(jpc), .rom_ins(rom_ins_a), .rom_addr(rom_addr_a),
    .pc(pc_a), .pc4(pc4_a), .ins(ins_a), .ins_valid(ins_valid_a), .halted(halted_a),
    .stall_cnt(stall_cnt_a), .redir_cnt(redir_cnt_a)
  );

  fetch_sequencer #(.RESET_PC(RST_B), .DELAY_SLOT(0), .CNT_W(3)) u_b (
    .clock(clk), .reset(reset), .stall(stall), .halt(halt), .pcsource(pcsource),
    .bpc(bpc), .da(da), .jpc(jpc), .rom_ins(rom_ins_b), .rom_addr(rom_addr_b),
    .pc(pc_b), .pc4(pc4_b), .ins(ins_b), .ins_valid(ins_valid_b), .halted(halted_b),
    .stall_cnt(stall_cnt_b), .redir_cnt(redir_cnt_b)
  );

  // Synchronous ROMs holding mem[i] = i (word index of the byte address).
  always @(posedge clk) begin
    rom_ins_a <= rom_addr_a >> 2;
    rom_ins_b <= rom_addr_b >> 2;
  end

  always_comb begin
    o_pc[0] = pc_a;  o_pc4[0] = pc4_a;  o_rom[0] = rom_addr_a;  o_ins[0] = ins_a;
    o_v[0]  = ins_valid_a;  o_h[0] = halted_a;
    o_sc[0] = 32'(stall_cnt_a);  o_rc[0] = 32'(redir_cnt_a);
    o_pc[1] = pc_b;  o_pc4[1] = pc4_b;  o_rom[1] = rom_addr_b;  o_ins[1] = ins_b;
    o_v[1]  = ins_valid_b;  o_h[1] = halted_b;
    o_sc[1] = 32'(stall_cnt_b);  o_rc[1] = 32'(redir_cnt_b);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] sel_npc(input logic [31:0] cur);
    case (pcsource)
      2'b00:   return cur + 32'd4;
      2'b01:   return bpc;
      2'b10:   return da;
      default: return jpc;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_state[i] = MB;
      m_pc[i]    = m_rst[i];
      m_sc[i]    = 0;
      m_rc[i]    = 0;
    end
  endtask

  // Expected outputs: in RUN the IF instruction is always mem[pc].
  task automatic check_all();
    logic [31:0] e_rom, e_ins;
    logic        e_v, e_h;
    for (int i = 0; i < 2; i++) begin
      e_rom = m_pc[i];
      e_ins = 32'h0;
      e_v   = 1'b0;
      e_h   = 1'b0;
      if (m_state[i] == MR && !reset) begin
        e_v   = 1'b1;
        e_ins = m_pc[i] >> 2;
        if (!stall) begin
          e_rom = sel_npc(m_pc[i]);
          if (pcsource != 2'b00 && m_ds[i] == 0) begin
            e_v   = 1'b0;
            e_ins = 32'h0;
          end
        end
      end else if (m_state[i] == MH && !reset) begin
        e_h = 1'b1;
      end
      check($sformatf("pc[%0d]", i),        o_pc[i],  m_pc[i]);
      check($sformatf("pc4[%0d]", i),       o_pc4[i], m_pc[i] + 32'd4);
      check($sformatf("rom_addr[%0d]", i),  o_rom[i], e_rom);
      check($sformatf("ins[%0d]", i),       o_ins[i], e_ins);
      check($sformatf("ins_valid[%0d]", i), 32'(o_v[i]), 32'(e_v));
      check($sformatf("halted[%0d]", i),    32'(o_h[i]), 32'(e_h));
      check($sformatf("stall_cnt[%0d]", i), o_sc[i],  m_sc[i]);
      check($sformatf("redir_cnt[%0d]", i), o_rc[i],  m_rc[i]);
    end
  endtask

  task automatic model_update();
    for (int i = 0; i < 2; i++) begin
      if (m_state[i] == MB) begin
        m_state[i] = MR;
      end else if (m_state[i] == MR) begin
        if (stall) begin
          if (m_sc[i] < m_cmax[i]) m_sc[i] = m_sc[i] + 1;
        end else begin
          if (pcsource != 2'b00 && m_rc[i] < m_cmax[i]) m_rc[i] = m_rc[i] + 1;
          m_pc[i] = sel_npc(m_pc[i]);
          if (halt) m_state[i] = MH;
        end
      end
    end
  endtask

  // One cycle: drive at negedge, check mid-low-phase, advance model at the edge.
  task automatic step(input logic s, input logic h, input logic [1:0] p,
                      input logic [31:0] b, input logic [31:0] d, input logic [31:0] j);
    @(negedge clk);
    stall = s;  halt = h;  pcsource = p;  bpc = b;  da = d;  jpc = j;
    #1;
    check_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    m_rst[0] = RST_A;  m_cmax[0] = 32'h0000_FFFF;  m_ds[0] = 1;
    m_rst[1] = RST_B;  m_cmax[1] = 32'h0000_0007;  m_ds[1] = 0;
    reset = 1'b1;  stall = 1'b0;  halt = 1'b0;  pcsource = 2'b00;
    bpc = 32'h0;  da = 32'h0;  jpc = 32'h0;
    model_reset();

    apply_reset();
    step(0, 0, 2'b00, 0, 0, 0);
    check("boot_pc_a", pc_a, 32'h0);
    step(0, 0, 2'b00, 0, 0, 0);
    step(0, 0, 2'b00, 0, 0, 0);
    check("pc_a_at_8", pc_a, 32'h8);
    check("wrap_pc_b", pc_b, 32'h0);

    repeat (3) step(1, 0, 2'b00, 0, 0, 0);
    check("stall_cnt_3", 32'(stall_cnt_a), 32'd3);
    check("stall_pc_held", pc_a, 32'h8);
    step(0, 0, 2'b00, 0, 0, 0);
    check("resume_pc_12", pc_a, 32'hC);

    step(0, 0, 2'b01, 32'h40, 0, 0);
    check("redir_pc_a", pc_a, 32'h40);
    check("redir_pc_b", pc_b, 32'h40);
    check("redir_cnt_1", 32'(redir_cnt_a), 32'd1);
    step(0, 0, 2'b00, 0, 0, 0);

    repeat (2) step(1, 0, 2'b11, 0, 0, 32'h80);
    check("stall_redir_held", pc_a, 32'h44);
    check("stall_redir_cnt", 32'(redir_cnt_a), 32'd1);
    step(0, 0, 2'b11, 0, 0, 32'h80);
    check("jump_pc_80", pc_a, 32'h80);
    check("redir_cnt_2", 32'(redir_cnt_a), 32'd2);

    step(0, 0, 2'b01, 32'h20, 0, 0);
    step(0, 1, 2'b00, 0, 0, 0);
    check("halted_a", 32'(halted_a), 32'd1);
    repeat (4) step($urandom_range(0, 1), $urandom_range(0, 1), 2'($urandom_range(0, 3)),
                    $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC);
    check("halted_stays", 32'(halted_a), 32'd1);
    check("halted_pc_frozen", pc_a, 32'h24);

    apply_reset();
    check("rst_pc_a", pc_a, RST_A);
    check("rst_sc_a", 32'(stall_cnt_a), 32'd0);
    check("rst_rc_a", 32'(redir_cnt_a), 32'd0);
    step(0, 0, 2'b00, 0, 0, 0);
    repeat (10) step(1, 0, 2'b00, 0, 0, 0);
    check("sat_stall_cnt_b", 32'(stall_cnt_b), 32'd7);
    check("stall_cnt_a_10", 32'(stall_cnt_a), 32'd10);

    for (int n = 0; n < 600; n++) begin
      logic       s, h;
      logic [1:0] p;
      if ($urandom_range(0, 79) == 0) apply_reset();
      s = ($urandom_range(0, 3) == 0);
      h = ($urandom_range(0, 47) == 0);
      p = h ? 2'b00 : 2'($urandom_range(0, 3));
      step(s, h, p, $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC,
           $urandom & 32'hFFFF_FFFC);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
